// File: rtl/psram_arbiter_if.sv
// Bus bundle between the two requesters (port A / port B), the arbiter and the psram block.
// slave  : arbiter side (consumes requests and psram status, drives done/rdata and psram inputs)
// master : environment side (requesters and psram)
interface psram_arbiter_if;
    localparam int unsigned AddrW = 24;
    localparam int unsigned DataW = 16;

    // port A
    logic             a_req;
    logic             a_we;
    logic [AddrW-1:0] a_addr;
    logic [DataW-1:0] a_wdata;
    logic             a_done;
    logic [DataW-1:0] a_rdata;

    // port B
    logic             b_req;
    logic             b_we;
    logic [AddrW-1:0] b_addr;
    logic [DataW-1:0] b_wdata;
    logic             b_done;
    logic [DataW-1:0] b_rdata;

    // completion qualifier shared by both ports
    logic             err;

    // psram side
    logic             qpi_on;
    logic             endcommand;
    logic [DataW-1:0] data_out;
    logic             read_sw;
    logic             write_sw;
    logic [AddrW-1:0] address;
    logic [DataW-1:0] data_in;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  qpi_on, endcommand, data_out,
        output a_done, a_rdata, b_done, b_rdata, err,
        output read_sw, write_sw, address, data_in
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output qpi_on, endcommand, data_out,
        input  a_done, a_rdata, b_done, b_rdata, err,
        input  read_sw, write_sw, address, data_in
    );
endinterface

// File: rtl/psram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of psram.
// Turns single-word req/done transactions into the level-held read_sw/write_sw
// strobes psram expects, once psram reports qpi_on.
// Optional build macro: PSRAM_ARB_TIMEOUT_EN enables the ISSUE watchdog (err on timeout);
// without it ISSUE waits for endcommand indefinitely and err stays 0.
module psram_arbiter #(
    parameter int unsigned ISSUE_MIN      = 3,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic            mem_clk,
    input logic            rst_n,
    psram_arbiter_if.slave bus
);
    localparam int unsigned AddrW = 24;
    localparam int unsigned DataW = 16;
    localparam int unsigned CntW  = 16;

    localparam logic [CntW-1:0] IssueMinC = CntW'(ISSUE_MIN);
    // GAP_CYCLES is at least 1, so the last gap count is GAP_CYCLES-1
    localparam logic [CntW-1:0] GapLastC  = CntW'(GAP_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutC  = CntW'(TIMEOUT_CYCLES);

`ifdef PSRAM_ARB_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    state_t           state_q,      state_d;
    port_t            last_grant_q, last_grant_d;
    port_t            grant_q,      grant_d;
    logic [CntW-1:0]  cnt_q,        cnt_d;
    logic             read_sw_q,    read_sw_d;
    logic             write_sw_q,   write_sw_d;
    logic [AddrW-1:0] address_q,    address_d;
    logic [DataW-1:0] data_in_q,    data_in_d;
    logic             a_done_q,     a_done_d;
    logic             b_done_q,     b_done_d;
    logic             err_q,        err_d;
    logic [DataW-1:0] a_rdata_q,    a_rdata_d;
    logic [DataW-1:0] b_rdata_q,    b_rdata_d;

    logic             pick_b;
    logic             grant_we;
    logic             cmd_end;
    logic             timed_out;

    // Next-state and next-output logic; done/err default low so they pulse for one cycle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        read_sw_d    = read_sw_q;
        write_sw_d   = write_sw_q;
        address_d    = address_q;
        data_in_d    = data_in_q;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        a_done_d     = 1'b0;
        b_done_d     = 1'b0;
        err_d        = 1'b0;
        pick_b       = 1'b0;
        grant_we     = 1'b0;
        cmd_end      = 1'b0;
        timed_out    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.qpi_on && (bus.a_req || bus.b_req)) begin
                    // B wins alone, or on a tie when A was served last
                    pick_b       = bus.b_req && (!bus.a_req || (last_grant_q == PORT_A));
                    grant_we     = pick_b ? bus.b_we : bus.a_we;
                    grant_d      = pick_b ? PORT_B : PORT_A;
                    last_grant_d = pick_b ? PORT_B : PORT_A;
                    address_d    = pick_b ? bus.b_addr  : bus.a_addr;
                    data_in_d    = pick_b ? bus.b_wdata : bus.a_wdata;
                    write_sw_d   = grant_we;
                    read_sw_d    = !grant_we;
                    cnt_d        = '0;
                    state_d      = S_ISSUE;
                end
            end

            S_ISSUE: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
                // endcommand still high from the previous command is masked early on
                if (bus.endcommand && (cnt_q >= IssueMinC)) begin
                    cmd_end = 1'b1;
                    if (read_sw_q) begin
                        if (grant_q == PORT_A) a_rdata_d = bus.data_out;
                        else                   b_rdata_d = bus.data_out;
                    end
                end else if (TimeoutEn && (cnt_q >= TimeoutC)) begin
                    cmd_end   = 1'b1;
                    timed_out = 1'b1;
                end
                if (cmd_end) begin
                    read_sw_d  = 1'b0;
                    write_sw_d = 1'b0;
                    a_done_d   = (grant_q == PORT_A);
                    b_done_d   = (grant_q == PORT_B);
                    err_d      = timed_out;
                    state_d    = S_DONE;
                end
            end

            S_DONE: begin
                cnt_d   = '0;
                state_d = S_GAP;
            end

            S_GAP: begin
                if (cnt_q >= GapLastC) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset also aborts an in-flight command.
    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= PORT_B;
            grant_q      <= PORT_A;
            cnt_q        <= '0;
            read_sw_q    <= 1'b0;
            write_sw_q   <= 1'b0;
            address_q    <= '0;
            data_in_q    <= '0;
            a_done_q     <= 1'b0;
            b_done_q     <= 1'b0;
            err_q        <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            read_sw_q    <= read_sw_d;
            write_sw_q   <= write_sw_d;
            address_q    <= address_d;
            data_in_q    <= data_in_d;
            a_done_q     <= a_done_d;
            b_done_q     <= b_done_d;
            err_q        <= err_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    // Drive the bundle from the registers.
    assign bus.read_sw  = read_sw_q;
    assign bus.write_sw = write_sw_q;
    assign bus.address  = address_q;
    assign bus.data_in  = data_in_q;
    assign bus.a_done   = a_done_q;
    assign bus.b_done   = b_done_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Randomized bench for psram_arbiter against a transaction-level timeline model.
module tb_psram_arbiter;
    localparam int unsigned IssueMin      = 3;
    localparam int unsigned GapCycles     = 2;
    localparam int unsigned TimeoutCycles = 20;
`ifdef PSRAM_ARB_TIMEOUT_EN
    localparam bit TimeoutOn = 1'b1;
`else
    localparam bit TimeoutOn = 1'b0;
`endif

    typedef enum int {M_IDLE, M_BUSY, M_POST} mmode_t;

    logic mem_clk = 1'b0;
    logic rst_n;

    psram_arbiter_if bus ();

    psram_arbiter #(
        .ISSUE_MIN      (IssueMin),
        .GAP_CYCLES     (GapCycles),
        .TIMEOUT_CYCLES (TimeoutCycles)
    ) dut (
        .mem_clk (mem_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 mem_clk = ~mem_clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // requesters
    bit          rq_en   [2];
    bit          rq_req  [2];
    bit          rq_we   [2];
    logic [23:0] rq_addr [2];
    logic [15:0] rq_wdata[2];
    bit          keep_req;

    // stimulus knobs
    bit          drv_rst;
    bit          drv_qpi;
    int          ec_mode;     // 0 random, 1 scripted by issue cycle, 2 held low
    bit [31:0]   ec_script;
    bit          dout_rand;

    // reference model
    mmode_t      m_mode;
    int          m_port;
    int          m_last;
    bit          m_we;
    int          m_n;
    int          m_post;
    logic        e_rd, e_wr, e_err;
    logic        e_done [2];
    logic [23:0] e_addr;
    logic [15:0] e_din;
    logic [15:0] e_rdata[2];

    int          dones[$];    // completion order as seen on the DUT

    task automatic new_txn(input int p);
        rq_req[p]   = 1'b1;
        rq_we[p]    = 1'($urandom_range(1));
        rq_addr[p]  = 24'($urandom);
        rq_wdata[p] = 16'($urandom);
    endtask

    task automatic model_finish(input bit to);
        e_rd = 1'b0;
        e_wr = 1'b0;
        e_done[m_port] = 1'b1;
        e_err = to;
        if (!to && !m_we) e_rdata[m_port] = bus.data_out;
        m_mode = M_POST;
        m_post = int'(GapCycles) + 1;
    endtask

    // Predict outputs for the next sample from the inputs just driven.
    task automatic predict();
        int p;
        e_done[0] = 1'b0;
        e_done[1] = 1'b0;
        e_err     = 1'b0;
        if (!rst_n) begin
            e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_din = '0;
            e_rdata[0] = '0; e_rdata[1] = '0;
            m_mode = M_IDLE; m_last = 1;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (bus.qpi_on && (rq_req[0] || rq_req[1])) begin
                        if (rq_req[0] && rq_req[1]) p = 1 - m_last;
                        else                        p = rq_req[0] ? 0 : 1;
                        m_port = p; m_last = p; m_we = rq_we[p];
                        e_wr = m_we; e_rd = !m_we;
                        e_addr = rq_addr[p]; e_din = rq_wdata[p];
                        m_n = 0; m_mode = M_BUSY;
                    end
                end
                M_BUSY: begin
                    m_n++;
                    if (bus.endcommand && (m_n > int'(IssueMin))) model_finish(1'b0);
                    else if (TimeoutOn && (m_n > int'(TimeoutCycles))) model_finish(1'b1);
                end
                default: begin
                    m_post--;
                    if (m_post == 0) m_mode = M_IDLE;
                end
            endcase
        end
    endtask

    // One cycle: check at the falling edge, then drive inputs and predict.
    task automatic step();
        @(negedge mem_clk);
        check("read_sw",  32'(bus.read_sw),  32'(e_rd));
        check("write_sw", 32'(bus.write_sw), 32'(e_wr));
        check("a_done",   32'(bus.a_done),   32'(e_done[0]));
        check("b_done",   32'(bus.b_done),   32'(e_done[1]));
        check("err",      32'(bus.err),      32'(e_err));
        check("address",  32'(bus.address),  32'(e_addr));
        check("data_in",  32'(bus.data_in),  32'(e_din));
        check("a_rdata",  32'(bus.a_rdata),  32'(e_rdata[0]));
        check("b_rdata",  32'(bus.b_rdata),  32'(e_rdata[1]));
        if (bus.a_done === 1'b1) dones.push_back(0);
        if (bus.b_done === 1'b1) dones.push_back(1);

        for (int p = 0; p < 2; p++) begin
            if (e_done[p]) begin
                if (rq_en[p] && (keep_req || ($urandom_range(3) != 0))) new_txn(p);
                else rq_req[p] = 1'b0;
            end else if (rq_en[p] && !rq_req[p] && ($urandom_range(1) == 1)) begin
                new_txn(p);
            end else if (rq_req[p] && (m_mode == M_BUSY) && (m_port == p)
                         && ($urandom_range(3) == 0)) begin
                // fields are only sampled at grant
                rq_we[p]    = 1'($urandom_range(1));
                rq_addr[p]  = 24'($urandom);
                rq_wdata[p] = 16'($urandom);
            end
        end

        rst_n       = drv_rst;
        bus.qpi_on  = drv_qpi;
        bus.a_req   = rq_req[0];
        bus.a_we    = rq_we[0];
        bus.a_addr  = rq_addr[0];
        bus.a_wdata = rq_wdata[0];
        bus.b_req   = rq_req[1];
        bus.b_we    = rq_we[1];
        bus.b_addr  = rq_addr[1];
        bus.b_wdata = rq_wdata[1];
        if (dout_rand) bus.data_out = 16'($urandom);
        case (ec_mode)
            0:       bus.endcommand = ($urandom_range(3) == 0);
            1:       bus.endcommand = (m_mode == M_BUSY) && (m_n < 31) && ec_script[5'(m_n + 1)];
            default: bus.endcommand = 1'b0;
        endcase
        predict();
    endtask

    initial begin
        int nd;
        rst_n = 1'b0; drv_rst = 1'b0; drv_qpi = 1'b0;
        ec_mode = 1; ec_script = '0; dout_rand = 1'b1; keep_req = 1'b0;
        for (int p = 0; p < 2; p++) begin
            rq_en[p] = 1'b0; rq_req[p] = 1'b0; rq_we[p] = 1'b0;
            rq_addr[p] = '0; rq_wdata[p] = '0;
            e_done[p] = 1'b0; e_rdata[p] = '0;
        end
        e_rd = 1'b0; e_wr = 1'b0; e_err = 1'b0; e_addr = '0; e_din = '0;
        m_mode = M_IDLE; m_last = 1; m_port = 0; m_we = 1'b0; m_n = 0; m_post = 0;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
        bus.qpi_on = 1'b0; bus.endcommand = 1'b0; bus.data_out = '0;

        // reset values
        repeat (2) step();

        // A write held pending while psram is not ready, then endcommand at issue cycles 1 and 5
        drv_rst = 1'b1;
        rq_we[0] = 1'b1; rq_addr[0] = 24'h000010; rq_wdata[0] = 16'hBEEF; rq_req[0] = 1'b1;
        ec_script = 32'h0000_0022;
        repeat (50) step();
        check("qpi_off_no_done", 32'(dones.size()), 32'd0);
        drv_qpi = 1'b1;
        repeat (2) step();
        check("write_sw_after_qpi", 32'(bus.write_sw), 32'd1);
        repeat (12) step();
        check("a_write_done_cnt", 32'(dones.size()), 32'd1);
        check("a_write_address",  32'(bus.address),  32'h000010);
        check("a_write_data_in",  32'(bus.data_in),  32'hBEEF);

        // B read capturing data_out
        rq_we[1] = 1'b0; rq_addr[1] = 24'h000020; rq_wdata[1] = 16'h5555; rq_req[1] = 1'b1;
        dout_rand = 1'b0; bus.data_out = 16'h1234;
        repeat (14) step();
        check("b_read_done_cnt", 32'(dones.size()), 32'd2);
        check("b_rdata_1234",    32'(bus.b_rdata),  32'h1234);
        check("a_rdata_kept",    32'(bus.a_rdata),  32'h0000);
        dout_rand = 1'b1;

        // both ports requesting continuously from reset: A, B, A, B
        drv_rst = 1'b0; step(); drv_rst = 1'b1;
        dones.delete();
        rq_en[0] = 1'b1; rq_en[1] = 1'b1; keep_req = 1'b1;
        new_txn(0); new_txn(1);
        ec_mode = 0;
        for (int i = 0; i < 400 && dones.size() < 4; i++) step();
        check("rr_done_cnt", 32'(dones.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("rr_order", 32'((dones.size() > i) ? dones[i] : -1), 32'(i % 2));
        end

        // reset during ISSUE aborts silently; A is served again afterwards
        rq_en[1] = 1'b0; rq_req[1] = 1'b0;
        ec_mode = 1; ec_script = 32'h0010_0000;
        for (int i = 0; i < 300 && !((m_mode == M_BUSY) && (m_port == 0) && (m_n == 2)); i++) step();
        check("strobe_before_abort", 32'(bus.read_sw | bus.write_sw), 32'd1);
        drv_rst = 1'b0; step(); drv_rst = 1'b1;
        nd = dones.size();
        step();
        check("strobe_after_abort", 32'(bus.read_sw | bus.write_sw), 32'd0);
        repeat (40) step();
        check("reissued_after_reset", 32'(dones.size() > nd), 32'd1);

`ifdef PSRAM_ARB_TIMEOUT_EN
        // watchdog: endcommand never comes
        drv_rst = 1'b0; step(); drv_rst = 1'b1;
        rq_en[0] = 1'b0; new_txn(0);
        ec_mode = 2;
        for (int i = 0; i < 80 && (bus.a_done !== 1'b1); i++) step();
        check("timeout_done", 32'(bus.a_done), 32'd1);
        check("timeout_err",  32'(bus.err),    32'd1);
        ec_mode = 0; new_txn(0);
        repeat (30) step();
`endif

        // random traffic with qpi_on glitches and occasional resets
        rq_en[0] = 1'b1; rq_en[1] = 1'b1; keep_req = 1'b0; ec_mode = 0;
        for (int i = 0; i < 2000; i++) begin
            drv_qpi = ($urandom_range(7) != 0);
            drv_rst = ($urandom_range(299) != 0);
            step();
        end
        drv_rst = 1'b1; drv_qpi = 1'b1;
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
